ahb_bus_arbiter: RTL and testbench

- Shared-bus arbiter for the AHB system bus.
- Grants the bus to one of NUM_MASTERS requesters (IAHB, DAHB, debug, DMA) from their HBUSREQx/HLOCKx.
- Drives the HGRANTx, HMASTER, HMASTLOCK and data-phase owner outputs that the address/data muxes and slaves use.
- Honours locked sequences, fixed-length bursts and a parked default master.

---
 rtl/ahb_bus_arbiter_pkg.sv | 41 ++++
 rtl/ahb_arb_pick.sv | 34 +++
 rtl/ahb_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared AHB encodings and burst-length decode for the bus arbiter.
// Imported by the arbiter top and its pick sub-module.
package ahb_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam int BURST_CNT_W = 4;

  localparam logic [BURST_CNT_W-1:0] BLEN_M1_1  = 4'd0;
  localparam logic [BURST_CNT_W-1:0] BLEN_M1_4  = 4'd3;
  localparam logic [BURST_CNT_W-1:0] BLEN_M1_8  = 4'd7;
  localparam logic [BURST_CNT_W-1:0] BLEN_M1_16 = 4'd15;

  // Beats remaining after the NONSEQ beat; undefined INCR counts as a single beat.
  function automatic logic [BURST_CNT_W-1:0] burst_len_m1(input logic [2:0] hburst);
    logic [BURST_CNT_W-1:0] len_m1;
    case (hburst)
      HBURST_SINGLE, HBURST_INCR:  len_m1 = BLEN_M1_1;
      HBURST_WRAP4,  HBURST_INCR4: len_m1 = BLEN_M1_4;
      HBURST_WRAP8,  HBURST_INCR8: len_m1 = BLEN_M1_8;
      HBURST_WRAP16, HBURST_INCR16: len_m1 = BLEN_M1_16;
      default:                     len_m1 = BLEN_M1_1;
    endcase
    return len_m1;
  endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Combinational winner selection: fixed priority (index 0 highest) or
// round-robin starting just after the last granted master.
module ahb_arb_pick #(
  parameter int NUM_MASTERS    = 4,
  parameter int MASTER_W       = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [MASTER_W-1:0]    i_rr_last,
  input  logic                   i_round_robin,
  output logic [MASTER_W-1:0]    o_winner
);

  int   w_cand;
  logic w_found;

  always_comb begin
    o_winner = MASTER_W'(DEFAULT_MASTER);
    w_found  = 1'b0;
    w_cand   = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (i_round_robin) begin
        w_cand = (int'(i_rr_last) + 1 + k) % NUM_MASTERS;
      end else begin
        w_cand = k;
      end
      if (!w_found && i_req[w_cand[MASTER_W-1:0]]) begin
        w_found  = 1'b1;
        o_winner = w_cand[MASTER_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB shared-bus arbiter: registered one-hot grant, burst/lock-aware
// re-arbitration and the address/data-phase ownership pipeline.
module ahb_bus_arbiter
  import ahb_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int MASTER_W       = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int ROUND_ROBIN    = 1
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic                   HREADY,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MASTER_W-1:0]    HMASTER,
  output logic                   HMASTLOCK,
  output logic [MASTER_W-1:0]    HMASTER_D
);

  localparam logic [MASTER_W-1:0]    DEF_IDX = MASTER_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] r_grant_oh_p0;
  logic [MASTER_W-1:0]    r_grant_idx_p0;
  logic [MASTER_W-1:0]    r_rr_last;
  logic [BURST_CNT_W-1:0] r_burst_cnt;
  logic [MASTER_W-1:0]    r_addr_owner_p1;
  logic                   r_addr_lock_p1;
  logic [MASTER_W-1:0]    r_data_owner_p2;

  htrans_e                w_htrans;
  logic [BURST_CNT_W-1:0] w_blen_m1;
  logic [BURST_CNT_W-1:0] w_remaining;
  logic [BURST_CNT_W-1:0] w_burst_cnt_nxt;
  logic                   w_lock_hold;
  logic                   w_rearb_ok;
  logic                   w_any_req;
  logic [MASTER_W-1:0]    w_pick;
  logic [NUM_MASTERS-1:0] w_pick_oh;

  assign w_htrans    = htrans_e'(HTRANS);
  assign w_blen_m1   = burst_len_m1(HBURST);
  assign w_remaining = (w_htrans == HTRANS_NONSEQ) ? w_blen_m1 : r_burst_cnt;
  assign w_any_req   = |HBUSREQ;

  // HMASTLOCK keeps the grant one transfer past HLOCK falling, covering the last locked beat.
  assign w_lock_hold = HLOCK[r_grant_idx_p0] | r_addr_lock_p1;

  // Handing over on the penultimate beat gives a bubble-free switch after the last one.
  assign w_rearb_ok = HREADY & ~w_lock_hold
                    & (w_remaining <= BURST_CNT_W'(1))
                    & (w_htrans != HTRANS_BUSY);

  ahb_arb_pick #(
    .NUM_MASTERS   (NUM_MASTERS),
    .MASTER_W      (MASTER_W),
    .DEFAULT_MASTER(DEFAULT_MASTER)
  ) u_pick (
    .i_req        (HBUSREQ),
    .i_rr_last    (r_rr_last),
    .i_round_robin(ROUND_ROBIN != 0),
    .o_winner     (w_pick)
  );

  always_comb begin
    w_pick_oh = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_pick == MASTER_W'(i)) w_pick_oh[i] = 1'b1;
    end
  end

  always_comb begin
    w_burst_cnt_nxt = r_burst_cnt;
    case (w_htrans)
      HTRANS_NONSEQ: w_burst_cnt_nxt = w_blen_m1;
      HTRANS_SEQ: begin
        if (r_burst_cnt != '0) w_burst_cnt_nxt = r_burst_cnt - BURST_CNT_W'(1);
      end
      HTRANS_IDLE:   w_burst_cnt_nxt = '0;
      default:       w_burst_cnt_nxt = r_burst_cnt;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_burst_cnt <= '0;
    end else if (HREADY) begin
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // Stage p0: grant register and round-robin pointer
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_grant_oh_p0  <= DEF_OH;
      r_grant_idx_p0 <= DEF_IDX;
      r_rr_last      <= DEF_IDX;
    end else if (w_rearb_ok) begin
      r_grant_oh_p0  <= w_pick_oh;
      r_grant_idx_p0 <= w_pick;
      if (w_any_req) r_rr_last <= w_pick;
    end
  end

  // Stage p1/p2: address-phase owner, then data-phase owner, advancing on HREADY
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr_owner_p1 <= DEF_IDX;
      r_addr_lock_p1  <= 1'b0;
      r_data_owner_p2 <= DEF_IDX;
    end else if (HREADY) begin
      r_addr_owner_p1 <= r_grant_idx_p0;
      r_addr_lock_p1  <= HLOCK[r_grant_idx_p0];
      r_data_owner_p2 <= r_addr_owner_p1;
    end
  end

  assign HGRANT    = r_grant_oh_p0;
  assign HMASTER   = r_addr_owner_p1;
  assign HMASTLOCK = r_addr_lock_p1;
  assign HMASTER_D = r_data_owner_p2;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_ahb_bus_arbiter;

  localparam int N = 4;
  localparam logic [8:0] RESET_VEC = 9'b0001_00_0_00;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic [3:0] HBUSREQ = 4'b0000;
  logic [3:0] HLOCK = 4'b0000;
  logic       HREADY = 1'b1;
  logic [1:0] HTRANS = 2'b00;
  logic [2:0] HBURST = 3'b000;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;
  logic [1:0] HMASTER_D;

  int checks = 0;
  int errors = 0;

  int m_gidx = 0;
  int m_rr   = 0;
  int m_cnt  = 0;
  int m_hm   = 0;
  int m_hml  = 0;
  int m_hmd  = 0;
  int blen [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  always #5 HCLK = ~HCLK;

  ahb_bus_arbiter #(
    .NUM_MASTERS(4), .MASTER_W(2), .DEFAULT_MASTER(0), .ROUND_ROBIN(1)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HREADY(HREADY), .HTRANS(HTRANS), .HBURST(HBURST), .HGRANT(HGRANT),
    .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK), .HMASTER_D(HMASTER_D)
  );

  wire [8:0] dut_vec = {HGRANT, HMASTER, HMASTLOCK, HMASTER_D};

  function automatic logic [8:0] model_vec();
    logic [3:0] oh;
    logic [1:0] hm, hmd;
    logic       lk;
    oh  = 4'b0001 << m_gidx;
    hm  = m_hm[1:0];
    hmd = m_hmd[1:0];
    lk  = (m_hml != 0);
    return {oh, hm, lk, hmd};
  endfunction

  // Round-robin: scan the rotation starting one past the last winner.
  function automatic int model_pick(input logic [3:0] req);
    int idx;
    if (req == 4'b0000) return 0;
    for (int k = 1; k <= N; k++) begin
      idx = (m_rr + k) % N;
      if (req[idx[1:0]]) return idx;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_gidx = 0; m_rr = 0; m_cnt = 0; m_hm = 0; m_hml = 0; m_hmd = 0;
  endtask

  // Advance model and DUT by one clock using the currently driven inputs.
  task automatic step();
    int blm1, rem, pk;
    int n_gidx, n_rr, n_cnt, n_hm, n_hml, n_hmd;
    bit lh, ok;
    blm1 = blen[HBURST] - 1;
    rem  = (HTRANS == 2'b10) ? blm1 : m_cnt;
    lh   = HLOCK[m_gidx[1:0]] || (m_hml != 0);
    ok   = HREADY && !lh && (rem <= 1) && (HTRANS != 2'b01);
    pk   = model_pick(HBUSREQ);
    n_gidx = m_gidx; n_rr = m_rr; n_cnt = m_cnt;
    n_hm = m_hm; n_hml = m_hml; n_hmd = m_hmd;
    if (HREADY) begin
      if (HTRANS == 2'b10)      n_cnt = blm1;
      else if (HTRANS == 2'b11) n_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
      else if (HTRANS == 2'b00) n_cnt = 0;
      n_hm  = m_gidx;
      n_hml = HLOCK[m_gidx[1:0]] ? 1 : 0;
      n_hmd = m_hm;
    end
    if (ok) begin
      n_gidx = pk;
      if (HBUSREQ != 4'b0000) n_rr = pk;
    end
    @(posedge HCLK);
    #1;
    m_gidx = n_gidx; m_rr = n_rr; m_cnt = n_cnt;
    m_hm = n_hm; m_hml = n_hml; m_hmd = n_hmd;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    HBUSREQ = 4'b1111;
    repeat (2) @(posedge HCLK);
    #1;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_values: got %b expected %b", dut_vec, RESET_VEC);
    end
    HBUSREQ = 4'b0000;
    HRESETn = 1'b1;
    model_reset();
  endtask

  task automatic test_idle_park();
    HBUSREQ = 4'b0000; HLOCK = 4'b0000; HTRANS = 2'b00; HBURST = 3'b000; HREADY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL idle_park cyc %0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
    checks++;
    if ({HGRANT, HMASTER, HMASTLOCK} !== 7'b0001_00_0) begin
      errors++;
      $display("FAIL idle_park_final: got %b expected 0001000", {HGRANT, HMASTER, HMASTLOCK});
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    logic [3:0] exp_oh;
    HBUSREQ = 4'b1111; HTRANS = 2'b10; HBURST = 3'b000;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_oh = 4'b0001 << exp_seq[i];
      checks++;
      if (HGRANT !== exp_oh) begin
        errors++;
        $display("FAIL rr_sequence step %0d: got %b expected %b", i, HGRANT, exp_oh);
      end
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL rr_model step %0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_incr4_hold();
    logic [1:0] tr [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
    logic [3:0] eg [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0010};
    HBUSREQ = 4'b0100; HTRANS = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL incr4_setup cyc %0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
    HBUSREQ = 4'b0110; HBURST = 3'b011;
    for (int i = 0; i < 4; i++) begin
      HTRANS = tr[i];
      step();
      checks++;
      if (HGRANT !== eg[i]) begin
        errors++;
        $display("FAIL incr4_grant beat %0d: got %b expected %b", i + 1, HGRANT, eg[i]);
      end
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL incr4_model beat %0d: got %b expected %b", i + 1, dut_vec, model_vec());
      end
    end
    HBUSREQ = 4'b0010; HTRANS = 2'b10; HBURST = 3'b000;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL incr4_handover cyc %0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_lock();
    HBUSREQ = 4'b1000; HLOCK = 4'b1000; HTRANS = 2'b00; HBURST = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL lock_setup cyc %0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
    HBUSREQ = 4'b1111; HTRANS = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (HGRANT !== 4'b1000 || HMASTLOCK !== 1'b1) begin
        errors++;
        $display("FAIL lock_held xfer %0d: got grant %b lock %b expected 1000 1", i, HGRANT, HMASTLOCK);
      end
    end
    HLOCK = 4'b0000;
    step();
    checks++;
    if (HGRANT !== 4'b1000) begin
      errors++;
      $display("FAIL lock_tail: got %b expected 1000", HGRANT);
    end
    step();
    checks++;
    if (HGRANT !== 4'b0001) begin
      errors++;
      $display("FAIL lock_release: got %b expected 0001", HGRANT);
    end
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL lock_model: got %b expected %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_wait_states();
    logic [8:0] frozen;
    HBUSREQ = 4'b0011; HBURST = 3'b101; HTRANS = 2'b10; HREADY = 1'b1;
    step();
    HTRANS = 2'b11;
    repeat (2) step();
    frozen = dut_vec;
    HREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (dut_vec !== frozen) begin
        errors++;
        $display("FAIL wait_frozen cyc %0d: got %b expected %b", i, dut_vec, frozen);
      end
    end
    HREADY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL wait_resume cyc %0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    HBUSREQ = 4'b0110; HBURST = 3'b111; HTRANS = 2'b10;
    step();
    HTRANS = 2'b11;
    repeat (3) step();
    #2;
    HRESETn = 1'b0;
    #1;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b expected %b", dut_vec, RESET_VEC);
    end
    HBUSREQ = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      @(posedge HCLK);
      #1;
      checks++;
      if (dut_vec !== RESET_VEC) begin
        errors++;
        $display("FAIL async_reset_hold cyc %0d: got %b expected %b", i, dut_vec, RESET_VEC);
      end
    end
    HRESETn = 1'b1;
    model_reset();
    HTRANS = 2'b00; HBURST = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL post_reset cyc %0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      HBUSREQ = 4'($urandom_range(0, 15));
      HLOCK   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      HREADY  = ($urandom_range(0, 3) != 0);
      HTRANS  = 2'($urandom_range(0, 3));
      HBURST  = 3'($urandom_range(0, 7));
      step();
      checks++;
      if (dut_vec !== model_vec() || !$onehot(HGRANT)) begin
        errors++;
        $display("FAIL random cyc %0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_park();
    test_round_robin();
    test_incr4_hold();
    test_lock();
    test_wait_states();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
